// File: rtl/partial_mixer_pkg.sv
// partial_mixer_pkg: shared sample/amplitude types and output saturation helper.
//   sample_t : signed 16-bit audio / sine sample
//   amp_t    : unsigned Q0.16 amplitude
//   sat16    : clip a wide signed value to 16 bits, reporting whether it clipped
package partial_mixer_pkg;

    typedef logic signed [15:0] sample_t;
    typedef logic [15:0]        amp_t;

    localparam int AMP_FRAC_BITS = 16;

    typedef struct packed {
        logic    sat;
        sample_t val;
    } sat_t;

    function automatic sat_t sat16(input logic signed [63:0] x);
        sat_t r;
        r.sat = (x > 64'sd32767) || (x < -64'sd32768);
        r.val = (x > 64'sd32767)  ? 16'sh7FFF :
                (x < -64'sd32768) ? 16'sh8000 : x[15:0];
        return r;
    endfunction

endpackage

// File: rtl/partial_amp_ram.sv
// partial_amp_ram: simple dual-port amplitude RAM, synchronous read-first read.
//   clk       : system clock
//   i_wr_en   : write strobe, i_wr_addr / i_wr_data select location and value
//   i_rd_en   : read enable, i_rd_addr selects location
//   o_rd_data : data of i_rd_addr one cycle after i_rd_en (old value on collision)
module partial_amp_ram
    import partial_mixer_pkg::*;
#(
    parameter  int DEPTH = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  amp_t          i_wr_data,
    input  logic          i_rd_en,
    input  logic [AW-1:0] i_rd_addr,
    output amp_t          o_rd_data
);

    amp_t r_mem [DEPTH];
    amp_t r_rd_data;

    // No reset on the array so it maps onto block/distributed RAM.
    always_ff @(posedge clk) begin
        if (i_wr_en)
            r_mem[i_wr_addr] <= i_wr_data;
        if (i_rd_en)
            r_rd_data <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/partial_mixer.sv
// partial_mixer: scales each incoming partial sine sample by its amplitude and
// sums NUM_PARTIALS of them into one saturated 16-bit audio sample per frame.
//   clk, rst_n    : clock, synchronous active-low reset
//   sin_in        : Q2.14 sine sample, qualified by sin_valid (one partial per pulse)
//   frame_sync    : realigns the partial counter to 0 and aborts the frame in flight
//   amp_wr_*      : amplitude RAM write port (unsigned Q0.16 per partial)
//   sample_out    : mixed sample, qualified by the one-cycle sample_valid pulse
//   sat_flag      : sample_out was clipped; updates with sample_valid
module partial_mixer
    import partial_mixer_pkg::*;
#(
    parameter  int NUM_PARTIALS = 64,
    parameter  int ACC_WIDTH    = 24,
    parameter  int OUT_SHIFT    = 6,
    localparam int AW           = $clog2(NUM_PARTIALS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [15:0]   sin_in,
    input  logic          sin_valid,
    input  logic          frame_sync,
    input  logic          amp_wr_en,
    input  logic [AW-1:0] amp_wr_addr,
    input  logic [15:0]   amp_wr_data,
    output logic [15:0]   sample_out,
    output logic          sample_valid,
    output logic          sat_flag
);

    logic [AW-1:0]                r_idx;
    logic                         r_v1, r_v2, r_v3;
    logic                         r_first1, r_first2;
    logic                         r_last1, r_last2, r_last3;
    sample_t                      r_sin1;
    logic signed [32:0]           r_prod;
    logic signed [ACC_WIDTH-1:0]  r_acc;
    sample_t                      r_sample;
    logic                         r_valid;
    logic                         r_sat;

    logic [AW-1:0]                w_idx;
    logic                         w_first, w_last;
    amp_t                         w_amp;
    logic signed [32:0]           w_prod;
    logic signed [ACC_WIDTH-1:0]  w_term;
    logic                         w_fire;
    sat_t                         w_sat;

    // A sample arriving with frame_sync is partial 0 of the new frame.
    assign w_idx   = frame_sync ? '0 : r_idx;
    assign w_first = (w_idx == '0);
    assign w_last  = (w_idx == AW'(NUM_PARTIALS - 1));

    partial_amp_ram #(
        .DEPTH(NUM_PARTIALS)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (amp_wr_en),
        .i_wr_addr (amp_wr_addr),
        .i_wr_data (amp_wr_data),
        .i_rd_en   (sin_valid),
        .i_rd_addr (w_idx),
        .o_rd_data (w_amp)
    );

    // Amplitude is zero-extended so it multiplies as a positive value.
    assign w_prod = $signed({{17{r_sin1[15]}}, r_sin1}) * $signed({17'b0, w_amp});

    // Drop the amplitude fraction bits; the size cast sign-extends or trims to the accumulator.
    assign w_term = ACC_WIDTH'(r_prod >>> AMP_FRAC_BITS);

    // A frame completing in S3 while frame_sync arrives is discarded as well.
    assign w_fire = r_v3 & r_last3 & ~frame_sync;
    assign w_sat  = sat16(64'(r_acc >>> OUT_SHIFT));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx    <= '0;
            r_v1     <= 1'b0;
            r_v2     <= 1'b0;
            r_v3     <= 1'b0;
            r_acc    <= '0;
            r_sample <= '0;
            r_valid  <= 1'b0;
            r_sat    <= 1'b0;
        end else begin
            r_idx   <= sin_valid ? (w_last ? '0 : w_idx + AW'(1)) : w_idx;
            r_v1    <= sin_valid;
            r_v2    <= r_v1 & ~frame_sync;
            r_v3    <= r_v2 & ~frame_sync;
            r_valid <= w_fire;
            // The first partial reloads, so back-to-back frames never leak into each other.
            if (r_v2)
                r_acc <= r_first2 ? w_term : r_acc + w_term;
            if (w_fire) begin
                r_sample <= w_sat.val;
                r_sat    <= w_sat.sat;
            end
        end
    end

    // Datapath registers carry no reset; their valid bits gate every use.
    always_ff @(posedge clk) begin
        if (sin_valid) begin
            r_sin1   <= sin_in;
            r_first1 <= w_first;
            r_last1  <= w_last;
        end
        if (r_v1) begin
            r_prod   <= w_prod;
            r_first2 <= r_first1;
            r_last2  <= r_last1;
        end
        if (r_v2)
            r_last3 <= r_last2;
    end

    assign sample_out   = r_sample;
    assign sample_valid = r_valid;
    assign sat_flag     = r_sat;

endmodule

// File: tb/tb_partial_mixer.sv
// tb_partial_mixer: directed vector bench for partial_mixer with NUM_PARTIALS=4,
// ACC_WIDTH=20; three instances share inputs and differ only in OUT_SHIFT (0,1,2).
module tb_partial_mixer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] sin_in = '0;
    logic        sin_valid = 1'b0;
    logic        frame_sync = 1'b0;
    logic        amp_wr_en = 1'b0;
    logic [1:0]  amp_wr_addr = '0;
    logic [15:0] amp_wr_data = '0;
    logic [15:0] so [3];
    logic        sv [3];
    logic        sf [3];

    partial_mixer #(.NUM_PARTIALS(4), .ACC_WIDTH(20), .OUT_SHIFT(0)) u0 (
        .clk(clk), .rst_n(rst_n), .sin_in(sin_in), .sin_valid(sin_valid),
        .frame_sync(frame_sync), .amp_wr_en(amp_wr_en), .amp_wr_addr(amp_wr_addr),
        .amp_wr_data(amp_wr_data), .sample_out(so[0]), .sample_valid(sv[0]), .sat_flag(sf[0]));
    partial_mixer #(.NUM_PARTIALS(4), .ACC_WIDTH(20), .OUT_SHIFT(1)) u1 (
        .clk(clk), .rst_n(rst_n), .sin_in(sin_in), .sin_valid(sin_valid),
        .frame_sync(frame_sync), .amp_wr_en(amp_wr_en), .amp_wr_addr(amp_wr_addr),
        .amp_wr_data(amp_wr_data), .sample_out(so[1]), .sample_valid(sv[1]), .sat_flag(sf[1]));
    partial_mixer #(.NUM_PARTIALS(4), .ACC_WIDTH(20), .OUT_SHIFT(2)) u2 (
        .clk(clk), .rst_n(rst_n), .sin_in(sin_in), .sin_valid(sin_valid),
        .frame_sync(frame_sync), .amp_wr_en(amp_wr_en), .amp_wr_addr(amp_wr_addr),
        .amp_wr_data(amp_wr_data), .sample_out(so[2]), .sample_valid(sv[2]), .sat_flag(sf[2]));

    always #5 clk = ~clk;

    typedef struct {
        int          shift;
        logic [63:0] amps;
        logic [63:0] sins;
        logic [15:0] gaps;
        logic [15:0] exp_out;
        logic        exp_sat;
    } vec_t;

    vec_t vecs [7];
    int   errors = 0;
    int   checks = 0;
    int   pulses = 0;
    int   cur = 0;

    always @(negedge clk) if (sv[cur]) pulses++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] s, input logic fs, input logic we,
                         input logic [1:0] wa, input logic [15:0] wd);
        sin_in = s; sin_valid = 1'b1; frame_sync = fs;
        amp_wr_en = we; amp_wr_addr = wa; amp_wr_data = wd;
        tick;
        sin_valid = 1'b0; frame_sync = 1'b0; amp_wr_en = 1'b0;
    endtask

    task automatic write_amps(input logic [63:0] a);
        for (int i = 0; i < 4; i++) begin
            amp_wr_en = 1'b1; amp_wr_addr = 2'(i); amp_wr_data = a[16*i +: 16];
            tick;
        end
        amp_wr_en = 1'b0;
    endtask

    // Called right after the last sin_valid has been clocked in.
    task automatic await_sample(input string name, input logic [15:0] eo, input logic es);
        int lat = 1;
        while (!sv[cur] && lat < 12) begin
            tick;
            lat++;
        end
        check({name, " latency"}, lat, 4);
        check({name, " out"}, so[cur], eo);
        check({name, " sat"}, sf[cur], es);
        repeat (3) tick;
        check({name, " pulses"}, pulses, 1);
        check({name, " hold"}, so[cur], eo);
    endtask

    initial begin
        vecs[0] = '{2, 64'h8000_8000_8000_8000, 64'h4000_4000_4000_4000, 16'h0000, 16'h2000, 1'b0};
        vecs[1] = '{1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_7FFF_7FFF_7FFF, 16'h0000, 16'h7FFF, 1'b1};
        vecs[2] = '{1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000, 16'h0000, 16'h0000, 1'b0};
        vecs[3] = '{1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_8000_8000_8000, 16'h0000, 16'h8000, 1'b1};
        vecs[4] = '{0, 64'hFFFF_8000_4000_0000, 64'h4000_4000_4000_4000, 16'h3210, 16'h6FFF, 1'b0};
        vecs[5] = '{2, 64'h8000_8000_8000_8000, 64'hC000_C000_C000_C000, 16'h0101, 16'hE000, 1'b0};
        vecs[6] = '{0, 64'h8000_8000_8000_8000, 64'h7FFF_2000_C000_4000, 16'h0000, 16'h4FFF, 1'b0};

        repeat (2) tick;
        for (int k = 0; k < 3; k++) begin
            check("reset out", so[k], 16'h0000);
            check("reset valid", sv[k], 1'b0);
            check("reset sat", sf[k], 1'b0);
        end
        rst_n = 1'b1;
        tick;

        for (int v = 0; v < 7; v++) begin
            cur = vecs[v].shift;
            write_amps(vecs[v].amps);
            pulses = 0;
            for (int i = 0; i < 4; i++) begin
                repeat (int'(vecs[v].gaps[4*i +: 4])) tick;
                drive(vecs[v].sins[16*i +: 16], 1'b0, 1'b0, 2'd0, 16'h0000);
            end
            await_sample($sformatf("vec%0d", v), vecs[v].exp_out, vecs[v].exp_sat);
        end

        // frame_sync with the 3rd sample: last four samples form the frame
        cur = 0;
        write_amps(64'h8000_8000_8000_8000);
        pulses = 0;
        drive(16'h1000, 1'b0, 1'b0, 2'd0, 16'h0000);
        drive(16'h2000, 1'b0, 1'b0, 2'd0, 16'h0000);
        drive(16'h4000, 1'b1, 1'b0, 2'd0, 16'h0000);
        drive(16'h0800, 1'b0, 1'b0, 2'd0, 16'h0000);
        drive(16'hC000, 1'b0, 1'b0, 2'd0, 16'h0000);
        drive(16'h2000, 1'b0, 1'b0, 2'd0, 16'h0000);
        await_sample("fsync", 16'h1400, 1'b0);

        // reset after partial 2 aborts the frame and clears the output
        pulses = 0;
        drive(16'h4000, 1'b0, 1'b0, 2'd0, 16'h0000);
        drive(16'h4000, 1'b0, 1'b0, 2'd0, 16'h0000);
        drive(16'h4000, 1'b0, 1'b0, 2'd0, 16'h0000);
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        check("midrst out", so[0], 16'h0000);
        check("midrst sat", sf[0], 1'b0);
        repeat (6) tick;
        check("midrst pulses", pulses, 0);
        drive(16'h4000, 1'b0, 1'b0, 2'd0, 16'h0000);
        drive(16'h2000, 1'b0, 1'b0, 2'd0, 16'h0000);
        drive(16'h1000, 1'b0, 1'b0, 2'd0, 16'h0000);
        drive(16'h0800, 1'b0, 1'b0, 2'd0, 16'h0000);
        await_sample("postrst", 16'h3C00, 1'b0);

        // write amp[0] while partial 0 reads it: old value used, new one next frame
        cur = 2;
        pulses = 0;
        drive(16'h4000, 1'b0, 1'b1, 2'd0, 16'h0000);
        drive(16'h4000, 1'b0, 1'b0, 2'd0, 16'h0000);
        drive(16'h4000, 1'b0, 1'b0, 2'd0, 16'h0000);
        drive(16'h4000, 1'b0, 1'b0, 2'd0, 16'h0000);
        await_sample("collide old", 16'h2000, 1'b0);
        pulses = 0;
        for (int i = 0; i < 4; i++) drive(16'h4000, 1'b0, 1'b0, 2'd0, 16'h0000);
        await_sample("collide new", 16'h1800, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
